spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side companion to the current-based LIF neuron. It turns a 1-bit spike train back into 8-bit numbers. It produces two measures:
- a windowed firing-rate count, in spikes per fixed window;
- an inter-spike-interval (ISI) measurement, in enabled cycles between consecutive spikes.

It sits downstream of a neuron's `spike` output and gives the tile an observable, loggable value on the output pins.

## Interface

Parameters:
- `WINDOW_LOG2`, default 8: window length is 2^WINDOW_LOG2 enabled cycles. Legal range 2..12.
- `CNT_W`, default 8: width of the rate and ISI outputs. Both saturate at 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  enable. When 0, all state freezes and `spike` is ignored.
- `clear`  in  1  synchronous restart. Zeroes the window and ISI state; no valid pulses are issued.
- `spike`  in  1  spike input; one spike per high cycle, sampled only when `ena`=1.
- `rate`  out  CNT_W  spike count of the last completed window (saturated).
- `rate_valid`  out  1  one-cycle pulse when `rate` updates.
- `rate_sat`  out  1  set when the last completed window's count saturated.
- `isi`  out  CNT_W  last measured inter-spike interval (saturated).
- `isi_valid`  out  1  one-cycle pulse when `isi` updates.

## Operation

- **Reset.** `rst_n`=0 zeroes every register and every output.
  - Outputs read 0 the cycle after reset is asserted; the clear is asynchronous.
  - Asserting reset mid-window discards the partial window and any pending ISI.
- **Active cycle.** A cycle is active when `ena`=1 and `clear`=0. `clear` takes priority over `spike` and over a window boundary.
- **Window counter.**
  - `win_cnt` is WINDOW_LOG2 bits and increments on each active cycle.
  - The boundary cycle is the active cycle where `win_cnt` = 2^WINDOW_LOG2−1. `win_cnt` then wraps to 0.
- **Spike counter.**
  - `spk_cnt` is CNT_W bits, saturating. It increments on each active cycle with `spike`=1.
  - On the boundary cycle:
    - `rate` <= saturated(`spk_cnt` + `spike`).
    - `rate_sat` <= 1 if that sum reached or exceeded 2^CNT_W−1.
    - `rate_valid` <= 1.
    - `spk_cnt` <= 0.
  - A spike on the boundary cycle counts in the closing window only.
- **ISI FSM**, two states:
  - NO_REF: no previous spike since reset/clear. An active cycle with a spike sets `t` <= 0 and moves to TRACK, with no `isi_valid`.
  - TRACK: on an active cycle with no spike, `t` <= saturated(`t`+1). On an active cycle with a spike:
    - `isi` <= saturated(`t`+1).
    - `isi_valid` <= 1.
    - `t` <= 0.
    - Stay in TRACK.
  - `clear` returns the FSM to NO_REF and sets `t` <= 0.
- **Interval values.**
  - Spikes on consecutive active cycles give `isi`=1.
  - An interval of k active cycles gives `isi`=k, capped at 2^CNT_W−1.
  - `t` holds at its cap, so arbitrarily long gaps read as the cap.
- **Disabled cycles.**
  - `ena`=0 cycles count toward neither the window nor `t`; intervals are measured in enabled cycles.
  - `rate_valid` and `isi_valid` are 0 on any cycle following a non-active cycle.
- **Output holding.** `rate`, `rate_sat` and `isi` hold their values until the next update.

## Timing

- All outputs are registered. There are no combinational paths from inputs to outputs.
- `rate_valid` is high in the cycle after the boundary cycle, for exactly one cycle. Latency from boundary sample to visible `rate` is 1 cycle.
- `isi_valid` is high in the cycle after the spike sample, for exactly one cycle.
- `rate_valid` and `isi_valid` may assert in the same cycle; they are independent.
- Maximum `rate_valid` frequency: once per 2^WINDOW_LOG2 active cycles.
- No backpressure. The consumer must capture on the valid pulse, or read the held value later.

## Structure

- Shared package `lif_pkg`:
  - `CNT_W` and `WINDOW_LOG2` defaults;
  - the ISI FSM state enum (NO_REF, TRACK);
  - saturation-limit constant `CNT_MAX` = 2^CNT_W−1.
- Sub-module `sat_counter`, parameter W, with inputs `inc`, `clr`, `hold` and output `q`. It saturates at all-ones. It is instantiated twice, once for `spk_cnt` and once for `t`.
- Top-level glue holds the window counter, the FSM, and the output registers.

## Test plan

- **Reset:** assert `rst_n`=0 mid-window with `spike` toggling → all outputs 0 next cycle; after release, the first `rate_valid` comes exactly 256 active cycles later.
- **Periodic spikes:** spike every 4th cycle, `ena`=1, WINDOW_LOG2=8 → `rate`=64 and `rate_sat`=0 at each window. `isi`=4 with `isi_valid` every 4 cycles; the first spike gives no `isi_valid`.
- **Continuous spiking:** `spike`=1 for 300 cycles → first window reports `rate`=255, `rate_sat`=1. `isi`=1 on every cycle after the first spike.
- **Boundary spike:** a single spike only on the boundary cycle → that window reports `rate`=1; the next window reports 0.
- **Enable gaps:** spike, then 5 active + 10 disabled + 2 active cycles, then spike → `isi`=8, with no valid pulses during the `ena`=0 cycles.
- **Clear:** assert `clear` in TRACK with `t`=50, then spike twice 3 cycles apart → first spike gives no `isi_valid`; second gives `isi`=3. Window restarts from 0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF tile: default widths, saturation limit and
// the ISI tracker state encoding used by spike_rate_decoder.
package lif_pkg;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int CNT_MAX         = (1 << DEF_CNT_W) - 1;

  typedef enum logic {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } isi_state_e;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike-in / measurement-out bundle between a spike consumer and its driver.
interface spike_rate_decoder_if #(
  parameter int CNT_W = lif_pkg::DEF_CNT_W
);
  logic             ena;
  logic             clear;
  logic             spike;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_sat;
  logic [CNT_W-1:0] isi;
  logic             isi_valid;

  modport master (
    output ena, clear, spike,
    input  rate, rate_valid, rate_sat, isi, isi_valid
  );

  modport slave (
    input  ena, clear, spike,
    output rate, rate_valid, rate_sat, isi, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over hold, hold wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         hold,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (!hold && inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a 1-bit spike train into a windowed firing rate and an inter-spike
// interval, both saturating CNT_W-bit registered outputs.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] SAT_MAX = '1;

  logic                   active;
  logic                   do_clear;
  logic                   boundary;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       spk_cnt;
  logic [CNT_W-1:0]       t_cnt;
  logic [CNT_W-1:0]       rate_sum;
  logic [CNT_W-1:0]       isi_next;
  isi_state_e             state_q, state_d;
  logic                   isi_fire;

  logic [CNT_W-1:0]       rate_q;
  logic                   rate_valid_q;
  logic                   rate_sat_q;
  logic [CNT_W-1:0]       isi_q;
  logic                   isi_valid_q;

  // A disabled cycle freezes everything, including a pending clear.
  assign do_clear = bus.ena & bus.clear;
  assign active   = bus.ena & ~bus.clear;
  assign boundary = &win_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (do_clear) begin
      win_cnt <= '0;
    end else if (active) begin
      win_cnt <= win_cnt + WINDOW_LOG2'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (active & bus.spike),
    .clr  (do_clear | (active & boundary)),
    .hold (~bus.ena),
    .q    (spk_cnt)
  );

  // Interval timer only runs once a reference spike has been seen.
  sat_counter #(.W(CNT_W)) u_t_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (active & ~bus.spike & (state_q == TRACK)),
    .clr  (do_clear | (active & bus.spike)),
    .hold (~bus.ena),
    .q    (t_cnt)
  );

  assign rate_sum = (spk_cnt == SAT_MAX) ? SAT_MAX
                                         : spk_cnt + CNT_W'(bus.spike);
  assign isi_next = (t_cnt == SAT_MAX) ? SAT_MAX : t_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NO_REF;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    isi_fire = 1'b0;
    if (do_clear) begin
      state_d = NO_REF;
    end else if (active && bus.spike) begin
      state_d  = TRACK;
      isi_fire = (state_q == TRACK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      rate_sat_q   <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      isi_valid_q  <= 1'b0;
      if (active && boundary) begin
        rate_q       <= rate_sum;
        rate_sat_q   <= (rate_sum == SAT_MAX);
        rate_valid_q <= 1'b1;
      end
      if (isi_fire) begin
        isi_q       <= isi_next;
        isi_valid_q <= 1'b1;
      end
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.rate_sat   = rate_sat_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (WINDOW_LOG2=8, CNT_W=8) with
// hand-computed expectations.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  spike_rate_decoder_if #(.CNT_W(8)) bus ();

  spike_rate_decoder #(.WINDOW_LOG2(8), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, then sample just after the rising edge.
  task automatic cyc(input logic e, input logic c, input logic s);
    bus.ena   = e;
    bus.clear = c;
    bus.spike = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ena = 1'b0; bus.clear = 1'b0; bus.spike = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rate"},  bus.rate, 0);
    check({tag, "_rv"},    bus.rate_valid, 0);
    check({tag, "_rsat"},  bus.rate_sat, 0);
    check({tag, "_isi"},   bus.isi, 0);
    check({tag, "_iv"},    bus.isi_valid, 0);
  endtask

  initial begin
    int found;
    bus.ena = 1'b0; bus.clear = 1'b0; bus.spike = 1'b0;

    // Reset: mid-window async reset with spikes toggling
    do_reset();
    check_all_zero("rst_init");
    for (int i = 0; i <= 100; i++) cyc(1'b1, 1'b0, (i % 2) == 0);
    check("pre_rst_isi", bus.isi, 2);
    check("pre_rst_iv", bus.isi_valid, 1);
    #3;
    rst_n = 1'b0;
    bus.spike = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    bus.spike = 1'b0;
    check_all_zero("rst_next");
    rst_n = 1'b1;
    found = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (bus.rate_valid === 1'b1) begin
        found = n;
        break;
      end
    end
    check("rst_first_rv_cycles", found, 256);
    check("rst_first_rate", bus.rate, 0);

    // Periodic spikes every 4th cycle
    do_reset();
    for (int i = 0; i < 512; i++) begin
      cyc(1'b1, 1'b0, (i % 4) == 0);
      check("per_rv", bus.rate_valid, (i % 256) == 255);
      check("per_iv", bus.isi_valid, (i % 4) == 0 && i > 0);
      if (i >= 4) check("per_isi", bus.isi, 4);
      if (i == 255 || i == 511) begin
        check("per_rate", bus.rate, 64);
        check("per_rsat", bus.rate_sat, 0);
      end
    end

    // Continuous spiking: rate saturates, isi=1 every cycle
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      check("cont_rv", bus.rate_valid, i == 255);
      check("cont_iv", bus.isi_valid, i > 0);
      if (i > 0) check("cont_isi", bus.isi, 1);
      if (i >= 255) begin
        check("cont_rate", bus.rate, 255);
        check("cont_rsat", bus.rate_sat, 1);
      end
    end

    // Single spike on the boundary cycle
    do_reset();
    for (int i = 0; i < 512; i++) begin
      cyc(1'b1, 1'b0, i == 255);
      check("bnd_iv", bus.isi_valid, 0);
      if (i == 255) begin
        check("bnd_rv0", bus.rate_valid, 1);
        check("bnd_rate0", bus.rate, 1);
        check("bnd_rsat0", bus.rate_sat, 0);
      end
      if (i == 511) begin
        check("bnd_rv1", bus.rate_valid, 1);
        check("bnd_rate1", bus.rate, 0);
      end
    end

    // Enable gaps: disabled cycles (with spike high) are ignored
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      check("gap_rv_off", bus.rate_valid, 0);
      check("gap_iv_off", bus.isi_valid, 0);
    end
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("gap_iv", bus.isi_valid, 1);
    check("gap_isi", bus.isi, 8);
    cyc(1'b1, 1'b0, 1'b0);
    check("gap_iv_pulse", bus.isi_valid, 0);
    check("gap_isi_hold", bus.isi, 8);

    // ISI cap: long gap reads as 255, then t restarts
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("cap_iv", bus.isi_valid, 1);
    check("cap_isi", bus.isi, 255);
    cyc(1'b1, 1'b0, 1'b1);
    check("cap_isi_after", bus.isi, 1);

    // Clear in TRACK with t=50
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("clr_rv", bus.rate_valid, 0);
    check("clr_iv", bus.isi_valid, 0);
    cyc(1'b1, 1'b0, 1'b1);
    check("clr_first_iv", bus.isi_valid, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("clr_second_iv", bus.isi_valid, 1);
    check("clr_second_isi", bus.isi, 3);
    for (int j = 4; j < 256; j++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check("clr_win_rv", bus.rate_valid, j == 255);
    end
    check("clr_win_rate", bus.rate, 2);
    check("clr_win_rsat", bus.rate_sat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
